// File: rtl/shift_unit.sv
// Multi-cycle shifter/rotator: SLL, SRL, SRA and ROR, applying at most STEP bits per
// clock so the shift network stays narrow. Valid/ready handshake on both sides.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   data_r;
    logic [WIDTH-1:0]   data_s;
    logic [1:0]         op_r;
    logic [1:0]         op_s;
    logic [SHW-1:0]     rem_r;
    logic [SHW-1:0]     rem_s;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_s;
    logic               zero_r;
    logic               zero_s;
    logic [SHW-1:0]     amt_s;
    logic [WIDTH-1:0]   stepped_s;

    // One partial step. The working word keeps the operand's sign in its MSB, so an
    // arithmetic shift of the working word replicates the original sign bit.
    function automatic logic [WIDTH-1:0] step_op(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic [SHW-1:0]   amt
    );
        logic [2*WIDTH-1:0] dbl;
        dbl = {d, d} >> amt;
        case (op)
            OP_SLL:  step_op = d << amt;
            OP_SRL:  step_op = d >> amt;
            OP_SRA:  step_op = $signed(d) >>> amt;
            OP_ROR:  step_op = dbl[WIDTH-1:0];
            default: step_op = d;
        endcase
    endfunction

    // Next-state and datapath decisions for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s  = state_r;
        data_s   = data_r;
        op_s     = op_r;
        rem_s    = rem_r;
        result_s = result_r;
        zero_s   = zero_r;
        if (rem_r > STEP_W) begin
            amt_s = STEP_W;
        end else begin
            amt_s = rem_r;
        end
        stepped_s = step_op(data_r, op_r, amt_s);

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = SHIFT;
                    data_s  = in_data;
                    op_s    = in_op;
                    rem_s   = in_shamt;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_r == {SHW{1'b0}}) begin
                    state_s  = DONE;
                    result_s = data_r;
                    zero_s   = (data_r == {WIDTH{1'b0}});
                end else if (rem_r <= STEP_W) begin
                    state_s  = DONE;
                    rem_s    = {SHW{1'b0}};
                    data_s   = stepped_s;
                    result_s = stepped_s;
                    zero_s   = (stepped_s == {WIDTH{1'b0}});
                end else begin
                    state_s = SHIFT;
                    data_s  = stepped_s;
                    rem_s   = rem_r - STEP_W;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                rem_s   = {SHW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            data_r   <= {WIDTH{1'b0}};
            op_r     <= OP_SLL;
            rem_r    <= {SHW{1'b0}};
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            state_r  <= state_s;
            data_r   <= data_s;
            op_r     <= op_s;
            rem_r    <= rem_s;
            result_r <= result_s;
            zero_r   <= zero_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign out_data  = result_r;
    assign out_zero  = zero_r;

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit (WIDTH=32, STEP=4): results against a
// one-shot reference shift, latency, hold under back-pressure and reset mid-request.
module tb_shift_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [4:0]  in_shamt = 5'd0;
    logic [1:0]  in_op = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                             input int s);
        logic [31:0] r;
        case (op)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $signed(d) >>> s;
            default: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
        return r;
    endfunction

    // One full request; hold = cycles out_ready stays low in DONE, poke = retry in_valid then.
    task automatic run_req(input string tag, input logic [1:0] op, input logic [31:0] d,
                           input int s, input int hold, input bit poke);
        logic [31:0] exp;
        logic [31:0] res;
        int lat;
        int exp_lat;
        int rdy_bad;
        exp     = ref_shift(op, d, s);
        exp_lat = (s == 0) ? 1 : (s + 3) / 4;
        @(negedge clock);
        check({tag, "_idle_rdy"}, in_ready, 1);
        in_valid = 1'b1; in_data = d; in_op = op; in_shamt = s[4:0]; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0; in_data = $urandom; in_op = 2'($urandom); in_shamt = 5'($urandom);
        lat = 0;
        rdy_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) rdy_bad++;
            @(posedge clock); #1;
            lat++;
        end
        res = out_data;
        check({tag, "_data"}, res, exp);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_zero"}, out_zero, (exp == 32'h0));
        check({tag, "_busy"}, rdy_bad, 0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd7;
            end
            @(posedge clock); #1;
            check({tag, "_hold_data"}, out_data, exp);
            check({tag, "_hold_vld"}, {in_ready, out_valid}, 2'b01);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {in_ready, out_valid, busy}, 3'b100);
        check({tag, "_retain"}, out_data, exp);
    endtask

    initial begin
        int seen;
        int sh[8] = '{0, 1, 3, 4, 5, 8, 16, 31};

        repeat (2) @(posedge clock);
        #1;
        check("rst_state", {in_ready, out_valid, busy, out_zero}, 4'b1001);
        check("rst_data", out_data, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        run_req("sra_min", 2'b10, 32'h8000_0000, 31, 0, 1'b0);
        run_req("srl_31", 2'b01, 32'h8000_0000, 31, 0, 1'b0);
        run_req("sra_5", 2'b10, 32'h7FFF_FFFF, 5, 0, 1'b0);
        run_req("ror_1", 2'b11, 32'h0000_0001, 1, 0, 1'b0);
        run_req("sll_31", 2'b00, 32'h0000_0001, 31, 0, 1'b0);
        run_req("sll_0_hold", 2'b00, 32'h1234_5678, 0, 3, 1'b1);
        run_req("sll_nz", 2'b00, 32'hFFFF_FFFF, 31, 0, 1'b0);
        run_req("srl_zero", 2'b01, 32'h0000_0001, 1, 0, 1'b0);

        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 8; k++) begin
                run_req($sformatf("sweep_op%0d_s%0d", op, sh[k]), 2'(op),
                        32'hC3A5_0F96 ^ (32'h1111_1111 * k), sh[k], k % 3, 1'b0);
            end
        end

        // Reset in the middle of a long SRA: request must vanish with no out_valid pulse.
        @(negedge clock);
        in_valid = 1'b1; in_data = 32'h8000_0000; in_op = 2'b10; in_shamt = 5'd31;
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("mid_busy", {in_ready, busy}, 2'b01);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("mid_rst_state", {out_valid, in_ready, busy, out_zero}, 4'b0101);
        check("mid_rst_data", out_data, 32'h0);
        seen = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_pulse", seen, 0);
        out_ready = 1'b0;

        run_req("after_rst", 2'b11, 32'h0000_00F0, 4, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
